// File: rtl/disp_frame_arbiter.sv
// -----------------------------------------------------------------------------
// disp_frame_arbiter
//
// Owns the 8-digit seven-segment frame and decides every cycle which
// requester's 8 x 5-bit digit-code frame is sent to the scan/segment driver.
// Priority is ALERT > STAT > IDLE > BLANK. A non-alert owner is held on screen
// for a minimum time. Alerts are shown for a fixed duration, and a one-deep
// queue holds a second alert.
//
// Ports
//   sys_clk      system clock
//   sys_rst      synchronous, active-high reset
//   idle_valid   idle animation wants the display (level)
//   idle_frame   idle digit codes, digit k = bits [5k+4:5k], k=0 rightmost
//   stat_valid   status/money view wants the display (level)
//   stat_frame   status digit codes
//   alert_req    single-cycle alert request
//   alert_frame  alert digit codes, sampled only in the alert_req cycle
//   alert_ack    pulse one cycle after alert_req: request accepted
//   alert_drop   pulse one cycle after alert_req: queue full, request lost
//   alert_busy   an alert is shown or pending
//   frame_out    registered frame to the segment driver
//   frame_owner  registered owner: 0 blank, 1 idle, 2 status, 3 alert
//   owner_chg    pulse in the cycle frame_owner takes a new value
//
// Build option
//   DISP_ALERT_BLINK_EN  when defined, the alert frame blinks at 2 Hz
//                        (half-period CLK_HZ/4 cycles, visible first).
// -----------------------------------------------------------------------------
module disp_frame_arbiter #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int HOLD_MS    = 500,
   parameter int ALERT_MS   = 2000,
   parameter int BLANK_CODE = 19
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        idle_valid,
   input  logic [39:0] idle_frame,
   input  logic        stat_valid,
   input  logic [39:0] stat_frame,
   input  logic        alert_req,
   input  logic [39:0] alert_frame,
   output logic        alert_ack,
   output logic        alert_drop,
   output logic        alert_busy,
   output logic [39:0] frame_out,
   output logic [1:0]  frame_owner,
   output logic        owner_chg
);

   localparam int HOLD_CYC  = CLK_HZ / 1000 * HOLD_MS;
   localparam int ALERT_CYC = CLK_HZ / 1000 * ALERT_MS;
   localparam int HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam int ALERT_W   = (ALERT_CYC > 1) ? $clog2(ALERT_CYC) : 1;

   // Counters run 0..CYC-1, so the last count marks the final cycle of the
   // interval and the counter never needs to represent CYC itself.
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
   localparam logic [ALERT_W-1:0] ALERT_LAST = ALERT_W'(ALERT_CYC - 1);

   // Encoding doubles as the frame_owner code.
   typedef enum logic [1:0] {
      ST_BLANK = 2'd0,
      ST_IDLE  = 2'd1,
      ST_STAT  = 2'd2,
      ST_ALERT = 2'd3
   } state_t;

   state_t              state_reg, state_next, prio_state;
   logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
   logic [ALERT_W-1:0]  alert_cnt_reg, alert_cnt_next;
   logic                act_full_reg, act_full_next;
   logic [39:0]         act_frame_reg, act_frame_next;
   logic                pend_full_reg, pend_full_next;
   logic [39:0]         pend_frame_reg, pend_frame_next;
   logic                ack_reg, ack_next;
   logic                drop_reg, drop_next;
   logic [39:0]         frame_out_reg, frame_out_next;
   logic [1:0]          owner_reg;
   logic                owner_chg_reg;

   logic                hold_done;
   logic                alert_exp;
   logic                alert_restart;
   logic [39:0]         blank_frame;
   logic [39:0]         alert_view;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_blank
         assign blank_frame[5*gi +: 5] = 5'(BLANK_CODE);
      end
   endgenerate

   assign hold_done = (hold_cnt_reg == HOLD_LAST);
   assign alert_exp = (state_reg == ST_ALERT) && (alert_cnt_reg == ALERT_LAST);

   // A new alert starts its timer either on entry from another owner or when
   // a queued/simultaneous request replaces an expiring one.
   assign alert_restart = (state_next == ST_ALERT) &&
                          ((state_reg != ST_ALERT) || alert_exp);

   // Alert slots. An expiring active alert is retired first, so a request in
   // the expiry cycle sees the freed slot.
   always_comb begin : slot_comb
      act_full_next   = act_full_reg;
      act_frame_next  = act_frame_reg;
      pend_full_next  = pend_full_reg;
      pend_frame_next = pend_frame_reg;
      ack_next        = 1'b0;
      drop_next       = 1'b0;
      if (alert_exp) begin
         act_full_next  = pend_full_reg;
         act_frame_next = pend_frame_reg;
         pend_full_next = 1'b0;
      end
      if (alert_req) begin
         if (!act_full_next) begin
            act_full_next  = 1'b1;
            act_frame_next = alert_frame;
            ack_next       = 1'b1;
         end else if (!pend_full_next) begin
            pend_full_next  = 1'b1;
            pend_frame_next = alert_frame;
            ack_next        = 1'b1;
         end else begin
            drop_next = 1'b1;
         end
      end
   end

   always_comb begin : prio_comb
      if (stat_valid) begin
         prio_state = ST_STAT;
      end else if (idle_valid) begin
         prio_state = ST_IDLE;
      end else begin
         prio_state = ST_BLANK;
      end
   end

   // FSM: state register
   always_ff @(posedge sys_clk) begin : state_ff
      if (sys_rst) begin
         state_reg <= ST_BLANK;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM: next state
   always_comb begin : next_state_comb
      state_next = state_reg;
      case (state_reg)
         ST_BLANK: state_next = prio_state;
         ST_IDLE: begin
            if (hold_done) begin
               if (stat_valid) begin
                  state_next = ST_STAT;
               end else if (!idle_valid) begin
                  state_next = ST_BLANK;
               end
            end
         end
         ST_STAT: begin
            if (hold_done && !stat_valid) begin
               state_next = idle_valid ? ST_IDLE : ST_BLANK;
            end
         end
         ST_ALERT: begin
            if (alert_exp && !act_full_next) begin
               state_next = prio_state;
            end
         end
         default: state_next = ST_BLANK;
      endcase
      // A loaded alert preempts any owner, hold or not.
      if ((state_reg != ST_ALERT) && act_full_reg) begin
         state_next = ST_ALERT;
      end
   end

   // Timers: hold clears on every owner change (which covers entering IDLE or
   // STAT from anywhere); both counters saturate at their last count.
   always_comb begin : timer_comb
      if (state_next != state_reg) begin
         hold_cnt_next = '0;
      end else if (hold_cnt_reg != HOLD_LAST) begin
         hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
      end else begin
         hold_cnt_next = hold_cnt_reg;
      end

      if (alert_restart || (state_next != ST_ALERT)) begin
         alert_cnt_next = '0;
      end else if (alert_cnt_reg != ALERT_LAST) begin
         alert_cnt_next = alert_cnt_reg + ALERT_W'(1);
      end else begin
         alert_cnt_next = alert_cnt_reg;
      end
   end

`ifdef DISP_ALERT_BLINK_EN
   localparam int BLINK_CYC = (CLK_HZ / 4 > 1) ? CLK_HZ / 4 : 1;
   localparam int BLINK_W   = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

   logic [BLINK_W-1:0] blink_cnt_reg, blink_cnt_next;
   logic               blink_off_reg, blink_off_next;

   // Phase restarts (frame visible) with every new alert.
   always_comb begin : blink_comb
      blink_cnt_next = '0;
      blink_off_next = 1'b0;
      if ((state_next == ST_ALERT) && !alert_restart) begin
         if (blink_cnt_reg == BLINK_LAST) begin
            blink_off_next = ~blink_off_reg;
         end else begin
            blink_cnt_next = blink_cnt_reg + BLINK_W'(1);
            blink_off_next = blink_off_reg;
         end
      end
   end

   always_ff @(posedge sys_clk) begin : blink_ff
      if (sys_rst) begin
         blink_cnt_reg <= '0;
         blink_off_reg <= 1'b0;
      end else begin
         blink_cnt_reg <= blink_cnt_next;
         blink_off_reg <= blink_off_next;
      end
   end

   assign alert_view = blink_off_reg ? blank_frame : act_frame_reg;
`else
   assign alert_view = act_frame_reg;
`endif

   // FSM: outputs. IDLE/STAT follow their source live while valid and freeze
   // on the last registered frame once the owner drops valid during hold.
   always_comb begin : out_comb
      frame_out_next = frame_out_reg;
      case (state_reg)
         ST_BLANK: frame_out_next = blank_frame;
         ST_IDLE:  if (idle_valid) frame_out_next = idle_frame;
         ST_STAT:  if (stat_valid) frame_out_next = stat_frame;
         ST_ALERT: frame_out_next = alert_view;
         default:  frame_out_next = blank_frame;
      endcase
   end

   always_ff @(posedge sys_clk) begin : data_ff
      if (sys_rst) begin
         hold_cnt_reg   <= '0;
         alert_cnt_reg  <= '0;
         act_full_reg   <= 1'b0;
         act_frame_reg  <= '0;
         pend_full_reg  <= 1'b0;
         pend_frame_reg <= '0;
         ack_reg        <= 1'b0;
         drop_reg       <= 1'b0;
         frame_out_reg  <= blank_frame;
         owner_reg      <= 2'd0;
         owner_chg_reg  <= 1'b0;
      end else begin
         hold_cnt_reg   <= hold_cnt_next;
         alert_cnt_reg  <= alert_cnt_next;
         act_full_reg   <= act_full_next;
         act_frame_reg  <= act_frame_next;
         pend_full_reg  <= pend_full_next;
         pend_frame_reg <= pend_frame_next;
         ack_reg        <= ack_next;
         drop_reg       <= drop_next;
         frame_out_reg  <= frame_out_next;
         owner_reg      <= state_reg;
         owner_chg_reg  <= (owner_reg != state_reg);
      end
   end

   assign alert_ack   = ack_reg;
   assign alert_drop  = drop_reg;
   assign alert_busy  = act_full_reg | pend_full_reg;
   assign frame_out   = frame_out_reg;
   assign frame_owner = owner_reg;
   assign owner_chg   = owner_chg_reg;

endmodule
